// File: rtl/skl_serial_adder_if.sv
// Operand request and result handshake bundle for the byte-serial adder.
// The master drives operands and result acceptance; the slave answers.
interface skl_serial_adder_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf, busy
  );
endinterface

// File: rtl/skl_serial_adder.sv
// Byte-serial wide adder: one 8-bit Sklansky prefix adder reused per byte,
// LSB first, with the inter-byte carry held in a register.
module skl8 (
  input  logic [7:0] x1,
  input  logic [7:0] x2,
  input  logic       cin,
  output logic [7:0] s,
  output logic       cout
);
  // One Sklansky level: bit i combines with the top of the lower block.
  function automatic logic [15:0] lvl(
    input logic [7:0] g,
    input logic [7:0] p,
    input int         sh
  );
    logic [7:0] go;
    logic [7:0] po;
    logic [2:0] j;
    go = g;
    po = p;
    for (int i = 0; i < 8; i++) begin
      if (((i >> sh) & 1) == 1) begin
        j     = 3'(((i >> sh) << sh) - 1);
        go[i] = g[i] | (p[i] & g[j]);
        po[i] = p[i] & p[j];
      end
    end
    return {go, po};
  endfunction

  logic [7:0] g0, p0, g1, p1, g2, p2, g3, p3;
  logic [8:0] c;

  always_comb begin
    g0 = x1 & x2;
    p0 = x1 ^ x2;
    {g1, p1} = lvl(g0, p0, 0);
    {g2, p2} = lvl(g1, p1, 1);
    {g3, p3} = lvl(g2, p2, 2);
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g3[i] | (p3[i] & cin);
    end
    s    = p0 ^ c[7:0];
    cout = c[8];
  end
endmodule

module skl_serial_adder #(
  parameter int WIDTH  = 32,
  parameter int NBYTES = WIDTH / 8
) (
  input logic              clk,
  input logic              rst,
  skl_serial_adder_if.slave bus
);
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  if ((WIDTH % 8) != 0 || WIDTH < 8 || NBYTES != WIDTH / 8) begin : g_bad
    $error("skl_serial_adder: WIDTH must be a multiple of 8 and >= 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nstate;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic [7:0]       x1, x2, s;
  logic             co;
  logic             last;
  logic             rdy;
  logic             vld;

  assign x1   = a_reg[8*idx +: 8];
  assign x2   = b_reg[8*idx +: 8];
  assign last = (idx == IW'(NBYTES - 1));

  skl8 u_skl8 (
    .x1  (x1),
    .x2  (x2),
    .cin (carry),
    .s   (s),
    .cout(co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    rdy    = 1'b0;
    vld    = 1'b0;
    unique case (state)
      IDLE: begin
        rdy = 1'b1;
        if (bus.in_valid) nstate = RUN;
      end
      RUN: begin
        if (last) nstate = DONE;
      end
      DONE: begin
        vld = 1'b1;
        if (bus.out_ready) nstate = IDLE;
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (state == IDLE) begin
      if (bus.in_valid) begin
        a_reg <= bus.a;
        b_reg <= bus.b;
        carry <= bus.cin;
        idx   <= '0;
      end
    end else if (state == RUN) begin
      sum_q[8*idx +: 8] <= s;
      carry             <= co;
      // idx parks on the last byte rather than wrapping
      if (last) begin
        cout_q <= co;
        ovf_q  <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ s[7] ^ co;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld;
  assign bus.busy      = !rdy;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_skl_serial_adder.sv
// Directed bench for skl_serial_adder at WIDTH=32 and WIDTH=8.
// Expected sums, carries and overflows are hand-computed constants.
module tb_skl_serial_adder;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   lat;
  int   n;
  bit   seen;

  always #5 clk = ~clk;

  skl_serial_adder_if #(.WIDTH(32)) bus32 ();
  skl_serial_adder_if #(.WIDTH(8))  bus8 ();

  skl_serial_adder #(.WIDTH(32)) u32 (
    .clk(clk),
    .rst(rst),
    .bus(bus32)
  );

  skl_serial_adder #(.WIDTH(8)) u8 (
    .clk(clk),
    .rst(rst),
    .bus(bus8)
  );

  task automatic chk(input string tag, input logic [63:0] o,
                     input logic [63:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("inv32_rdy_vld", bus32.in_ready & bus32.out_valid, 0);
    chk("inv32_busy", bus32.busy, !bus32.in_ready);
    chk("inv8_rdy_vld", bus8.in_ready & bus8.out_valid, 0);
    chk("inv8_busy", bus8.busy, !bus8.in_ready);
  endtask

  task automatic wait32(output int l);
    l = 0;
    while (!bus32.out_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  task automatic wait8(output int l);
    l = 0;
    while (!bus8.out_valid && l < 20) begin
      tick();
      l++;
    end
  endtask

  initial begin
    rst = 1'b0;
    bus32.in_valid = 0; bus32.a = '0; bus32.b = '0;
    bus32.cin = 0; bus32.out_ready = 0;
    bus8.in_valid = 0; bus8.a = '0; bus8.b = '0;
    bus8.cin = 0; bus8.out_ready = 0;
    #2 rst = 1'b1;
    #2;
    chk("rst_in_ready", bus32.in_ready, 1);
    chk("rst_out_valid", bus32.out_valid, 0);
    chk("rst_busy", bus32.busy, 0);
    chk("rst_sum", bus32.sum, 0);
    chk("rst_cout", bus32.cout, 0);
    chk("rst_ovf", bus32.ovf, 0);
    chk("rst8_in_ready", bus8.in_ready, 1);
    @(negedge clk) rst = 1'b0;
    tick();

    // FFFFFFFF + 1
    bus32.a = 32'hFFFF_FFFF; bus32.b = 32'h1; bus32.cin = 0;
    bus32.in_valid = 1;
    tick();
    bus32.in_valid = 0;
    chk("t1_in_ready_run", bus32.in_ready, 0);
    chk("t1_busy_run", bus32.busy, 1);
    wait32(lat);
    chk("t1_latency", lat, 4);
    chk("t1_sum", bus32.sum, 32'h0);
    chk("t1_cout", bus32.cout, 1);
    chk("t1_ovf", bus32.ovf, 0);
    bus32.out_ready = 1;
    tick();
    chk("t1_out_valid_drop", bus32.out_valid, 0);
    chk("t1_in_ready_back", bus32.in_ready, 1);
    bus32.out_ready = 0;

    // 7FFFFFFF + 1: signed overflow
    bus32.a = 32'h7FFF_FFFF; bus32.b = 32'h1; bus32.cin = 0;
    bus32.in_valid = 1;
    tick();
    bus32.in_valid = 0;
    wait32(lat);
    chk("t2_latency", lat, 4);
    chk("t2_sum", bus32.sum, 32'h8000_0000);
    chk("t2_cout", bus32.cout, 0);
    chk("t2_ovf", bus32.ovf, 1);
    bus32.out_ready = 1;
    tick();

    // back-to-back with out_ready high
    bus32.a = 32'h1234_5678; bus32.b = 32'h9ABC_DEF0; bus32.cin = 1;
    bus32.in_valid = 1;
    chk("t3_in_ready", bus32.in_ready, 1);
    tick();
    bus32.a = 32'h1; bus32.b = 32'h1; bus32.cin = 0;
    n = 0;
    seen = 0;
    while (!bus32.in_ready && n < 20) begin
      if (bus32.out_valid && !seen) begin
        seen = 1;
        chk("t3_latency", n, 4);
        chk("t3_sum", bus32.sum, 32'hACF1_3569);
        chk("t3_cout", bus32.cout, 0);
        chk("t3_ovf", bus32.ovf, 0);
      end
      tick();
      n++;
    end
    chk("t3_seen_result", seen, 1);
    chk("t3_spacing", n + 1, 6);
    tick();
    bus32.in_valid = 0;
    wait32(lat);
    chk("t3b_latency", lat, 4);
    chk("t3b_sum", bus32.sum, 32'h2);
    chk("t3b_cout", bus32.cout, 0);
    tick();
    bus32.out_ready = 0;

    // backpressure
    bus32.a = 32'hFF; bus32.b = 32'h1; bus32.cin = 0;
    bus32.in_valid = 1;
    tick();
    bus32.in_valid = 0;
    wait32(lat);
    chk("t4_sum", bus32.sum, 32'h100);
    for (int k = 0; k < 5; k++) begin
      bus32.in_valid = k[0];
      bus32.a = 32'hDEAD_0000 + 32'(k);
      tick();
      chk("t4_hold_valid", bus32.out_valid, 1);
      chk("t4_hold_sum", bus32.sum, 32'h100);
      chk("t4_hold_in_ready", bus32.in_ready, 0);
    end
    bus32.in_valid = 0;
    bus32.out_ready = 1;
    tick();
    chk("t4_release_valid", bus32.out_valid, 0);
    chk("t4_release_in_ready", bus32.in_ready, 1);
    chk("t4_sum_kept", bus32.sum, 32'h100);
    bus32.out_ready = 0;

    // reset while idx=2
    bus32.a = 32'h1111_1111; bus32.b = 32'h2222_2222; bus32.cin = 0;
    bus32.in_valid = 1;
    tick();
    bus32.in_valid = 0;
    tick();
    tick();
    chk("t5_busy_before", bus32.busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_out_valid", bus32.out_valid, 0);
    chk("t5_rst_in_ready", bus32.in_ready, 1);
    chk("t5_rst_sum", bus32.sum, 0);
    chk("t5_rst_busy", bus32.busy, 0);
    @(negedge clk) rst = 1'b0;
    tick();
    chk("t5_after_out_valid", bus32.out_valid, 0);
    chk("t5_after_in_ready", bus32.in_ready, 1);
    bus32.a = 32'h1; bus32.b = 32'h1; bus32.cin = 0;
    bus32.in_valid = 1;
    tick();
    bus32.in_valid = 0;
    wait32(lat);
    chk("t5_latency", lat, 4);
    chk("t5_sum", bus32.sum, 32'h2);
    bus32.out_ready = 1;
    tick();
    bus32.out_ready = 0;

    // WIDTH=8 instance
    bus8.a = 8'h80; bus8.b = 8'h80; bus8.cin = 0;
    bus8.in_valid = 1;
    tick();
    bus8.in_valid = 0;
    wait8(lat);
    chk("w8a_latency", lat, 1);
    chk("w8a_sum", bus8.sum, 8'h00);
    chk("w8a_cout", bus8.cout, 1);
    chk("w8a_ovf", bus8.ovf, 1);
    bus8.out_ready = 1;
    tick();
    bus8.out_ready = 0;
    bus8.a = 8'h7F; bus8.b = 8'h00; bus8.cin = 1;
    bus8.in_valid = 1;
    tick();
    bus8.in_valid = 0;
    wait8(lat);
    chk("w8b_latency", lat, 1);
    chk("w8b_sum", bus8.sum, 8'h80);
    chk("w8b_cout", bus8.cout, 0);
    chk("w8b_ovf", bus8.ovf, 1);
    bus8.out_ready = 1;
    tick();
    bus8.out_ready = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/skl_serial_adder.md
Name: skl_serial_adder

Overview:
- Sequential byte-serial wide adder built around one instance of the team's 8-bit Sklansky prefix adder (`skl8`).
- Accepts two WIDTH-bit operands and a carry-in over a valid/ready handshake.
- Feeds `skl8` one operand byte per cycle, LSB first, with the carry registered between bytes.
- Returns the registered WIDTH-bit sum, carry-out and signed overflow over a second valid/ready handshake. It is the operand-sequencing stage directly upstream of `skl8` and the result-collecting stage directly downstream of it.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of 8 and >= 8; any other value is an elaboration error.
- NBYTES, WIDTH/8, derived byte count; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A, sampled only on accept edge
- b  input  WIDTH  operand B, sampled only on accept edge
- cin  input  1  carry-in, sampled only on accept edge
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  registered a+b+cin modulo 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1
- ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async, rst=1): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. Byte index, carry and operand registers are cleared.
- Reset asserted mid-RUN or mid-DONE: the operation is discarded immediately and no out_valid is produced for it.

FSM states:
- IDLE: in_ready=1.
  - in_valid=1 at an edge -> latch a, b, cin into internal registers; idx=0; carry=cin; go to RUN.
- RUN: in_ready=0.
  - skl8 is driven combinationally with x1=a_reg byte[idx], x2=b_reg byte[idx], cin=carry.
  - Each edge: sum byte[idx] <= s; carry <= skl8 cout; idx <= idx+1.
  - If idx==NBYTES-1: ovf <= a_reg[WIDTH-1] ^ b_reg[WIDTH-1] ^ s[7] ^ skl8 cout; cout <= skl8 cout; go to DONE.
- DONE: out_valid=1.
  - sum, cout and ovf hold stable while out_valid=1 and out_ready=0.
  - out_ready=1 at an edge -> go to IDLE; out_valid drops.
  - sum, cout and ovf keep their last values until the next completion or reset.

Timing and latency:
- out_valid rises exactly NBYTES cycles after the accept edge.
- With out_ready held high, minimum initiation interval is NBYTES+2 cycles (accept, NBYTES RUN cycles, DONE handshake).
- No overlap between operations: in_valid is ignored outside IDLE, and operands changing outside IDLE have no effect.

Width rules:
- idx is clog2(NBYTES) bits, minimum 1. It never wraps within an operation and is reset to 0 on every accept.
- WIDTH=8 case: a single RUN cycle, latency 1.
- sum is built in place in one register. Bytes not yet computed during RUN are don't-care internally, but the sum port must not change while out_valid=1.

Invariants (assertion targets):
- in_ready and out_valid are never high together.
- busy == !in_ready.

Test Plan:
- WIDTH=32: a=0xFFFFFFFF, b=0x00000001, cin=0 -> out_valid 4 cycles after accept; sum=0x00000000, cout=1, ovf=0.
- WIDTH=32: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- WIDTH=32: a=0x12345678, b=0x9ABCDEF0, cin=1 -> sum=0xACF13569, cout=0, ovf=0; then accept next operands a=0x1, b=0x1, cin=0 -> sum=0x00000002; accept-to-accept spacing with out_ready=1 is 6 cycles.
- Backpressure: complete a=0x000000FF, b=0x00000001, then hold out_ready=0 for 5 cycles -> out_valid stays 1, sum stays 0x00000100, in_ready stays 0; in_valid pulses ignored. Raising out_ready -> IDLE next edge.
- Reset mid-RUN: assert rst while idx=2 -> out_valid=0, in_ready=1, sum=0 immediately without a clock edge; after release, a fresh 0x1+0x1 returns 0x00000002.
- WIDTH=8: a=0x80, b=0x80, cin=0 -> latency 1 cycle; sum=0x00, cout=1, ovf=1; a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
